// File: rtl/dtree_node_sequencer.sv
// Sequential decision-tree evaluator: one shared comparator walks a programmable
// node table one node per clock and returns the leaf class on a valid/ready port.
module dtree_node_sequencer #(
  parameter int NUM_FEATURES = 16,
  parameter int FEAT_W       = 8,
  parameter int NODE_AW      = 6,
  parameter int CLASS_W      = 4,
  parameter int MAX_DEPTH    = 15
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [NUM_FEATURES*FEAT_W-1:0]   in_features,
  input  logic                             cfg_we,
  input  logic [NODE_AW-1:0]               cfg_addr,
  input  logic [5+FEAT_W+2*NODE_AW-1:0]    cfg_wdata,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [CLASS_W-1:0]               out_class,
  output logic                             out_error,
  output logic                             busy
);

  localparam int ENTRY_W   = 5 + FEAT_W + 2*NODE_AW;
  localparam int NUM_NODES = 2**NODE_AW;
  localparam int DEPTH_W   = $clog2(MAX_DEPTH + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, WALK = 2'd1, DONE = 2'd2} state_t;

  state_t                         state, state_next;
  logic [ENTRY_W-1:0]             node_table [NUM_NODES];
  logic [NUM_FEATURES*FEAT_W-1:0] feat_reg;
  logic [NODE_AW-1:0]             node_ptr, node_ptr_next;
  logic [DEPTH_W-1:0]             depth, depth_next;
  logic [CLASS_W-1:0]             class_reg, class_next;
  logic                           error_reg, error_next;
  logic                           accept;

  logic [ENTRY_W-1:0] entry;
  logic               is_leaf;
  logic [3:0]         feat_idx;
  logic [FEAT_W-1:0]  thr;
  logic [NODE_AW-1:0] left, right;
  logic [FEAT_W-1:0]  sel_feat;

  assign accept = (state == IDLE) && in_valid;

  // Entry layout: {is_leaf, feat_idx[3:0], thr, left, right}
  assign entry    = node_table[node_ptr];
  assign is_leaf  = entry[ENTRY_W-1];
  assign feat_idx = entry[ENTRY_W-2 -: 4];
  assign thr      = entry[2*NODE_AW +: FEAT_W];
  assign left     = entry[NODE_AW +: NODE_AW];
  assign right    = entry[0 +: NODE_AW];

  // Out-of-range feature indices fall back to feature 0.
  always_comb begin
    sel_feat = feat_reg[0 +: FEAT_W];
    if (int'(feat_idx) < NUM_FEATURES)
      sel_feat = feat_reg[feat_idx*FEAT_W +: FEAT_W];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_NODES; i++)
        node_table[i] <= '0;
    end else if (cfg_we && (state == IDLE)) begin
      node_table[cfg_addr] <= cfg_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      feat_reg  <= '0;
      node_ptr  <= '0;
      depth     <= '0;
      class_reg <= '0;
      error_reg <= 1'b0;
    end else begin
      state     <= state_next;
      node_ptr  <= node_ptr_next;
      depth     <= depth_next;
      class_reg <= class_next;
      error_reg <= error_next;
      if (accept)
        feat_reg <= in_features;
    end
  end

  always_comb begin
    state_next    = state;
    node_ptr_next = node_ptr;
    depth_next    = depth;
    class_next    = class_reg;
    error_next    = error_reg;
    case (state)
      IDLE: begin
        if (in_valid) begin
          state_next    = WALK;
          node_ptr_next = '0;
          depth_next    = '0;
        end
      end
      WALK: begin
        if (is_leaf) begin
          class_next = thr[CLASS_W-1:0];
          error_next = 1'b0;
          state_next = DONE;
        end else if (depth == DEPTH_W'(MAX_DEPTH)) begin
          // Guards against cyclic tables, including the cleared reset table.
          class_next = '0;
          error_next = 1'b1;
          state_next = DONE;
        end else begin
          node_ptr_next = (sel_feat <= thr) ? left : right;
          depth_next    = depth + 1'b1;
        end
      end
      DONE: begin
        if (out_ready)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out_class = class_reg;
  assign out_error = error_reg;

endmodule

// File: tb/tb_dtree_node_sequencer.sv
// Bench for dtree_node_sequencer: cycle-level reference model plus directed
// vectors with hand-computed classes and latencies.
module tb_dtree_node_sequencer;
  localparam int NF = 16;
  localparam int MD = 15;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_features = '0;
  logic         cfg_we = 1'b0;
  logic [5:0]   cfg_addr = '0;
  logic [24:0]  cfg_wdata = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [3:0]   out_class;
  logic         out_error;
  logic         busy;

  dtree_node_sequencer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_features(in_features), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .out_valid(out_valid), .out_ready(out_ready),
    .out_class(out_class), .out_error(out_error), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [24:0] mk(input int leaf, input int fi, input int thr,
                                     input int l, input int r);
    return {1'(leaf), 4'(fi), 8'(thr), 6'(l), 6'(r)};
  endfunction

  function automatic logic [127:0] mkfeat(input logic [7:0] f15);
    logic [127:0] v;
    v = {$urandom(), $urandom(), $urandom(), $urandom()};
    v[127:120] = f15;
    return v;
  endfunction

  // ---------------- reference model ----------------
  typedef enum {M_IDLE, M_BUSY, M_DONE} mphase_t;
  logic [24:0] m_tbl [64];
  mphase_t     m_phase = M_IDLE;
  int          m_cnt, m_class, m_err;

  // Whole-tree evaluation in one go: class, error flag and cycles to result.
  task automatic model_walk(input logic [127:0] f, output int cls, output int err,
                            output int lat);
    int ptr;
    int fi;
    logic [24:0] e;
    logic [7:0] x;
    ptr = 0; cls = 0; err = 0; lat = 0;
    for (int d = 0; d <= MD; d++) begin
      e = m_tbl[ptr];
      if (e[24]) begin
        cls = int'(e[15:12]); lat = d + 1; return;
      end
      if (d == MD) begin
        err = 1; cls = 0; lat = MD + 1; return;
      end
      fi = int'(e[23:20]);
      if (fi >= NF) fi = 0;
      x = f[fi*8 +: 8];
      ptr = (x <= e[19:12]) ? int'(e[11:6]) : int'(e[5:0]);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        for (int i = 0; i < 64; i++) m_tbl[i] = '0;
        m_phase = M_IDLE;
      end
      chk("m_in_ready", int'(in_ready), int'(m_phase == M_IDLE));
      chk("m_out_valid", int'(out_valid), int'(m_phase == M_DONE));
      chk("m_busy", int'(busy), int'(m_phase != M_IDLE));
      if (m_phase == M_DONE) begin
        chk("m_class", int'(out_class), m_class);
        chk("m_error", int'(out_error), m_err);
      end
      if (!rst) begin
        case (m_phase)
          M_IDLE: begin
            if (cfg_we) m_tbl[cfg_addr] = cfg_wdata;
            if (in_valid) begin
              model_walk(in_features, m_class, m_err, m_cnt);
              m_phase = M_BUSY;
            end
          end
          M_BUSY: begin
            m_cnt--;
            if (m_cnt == 0) m_phase = M_DONE;
          end
          M_DONE: if (out_ready) m_phase = M_IDLE;
          default: m_phase = M_IDLE;
        endcase
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic write_node(input int addr, input logic [24:0] data);
    cfg_we = 1'b1; cfg_addr = 6'(addr); cfg_wdata = data;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic run_sample(input string name, input logic [7:0] f15, input int exp_cls,
                            input int exp_err, input int exp_lat, input int hold,
                            output int acc_cyc);
    int lat;
    int guard;
    logic rdy;
    out_ready   = (hold == 0);
    in_features = mkfeat(f15);
    in_valid    = 1'b1;
    guard = 0;
    do begin
      rdy = in_ready;
      @(posedge clk); #1;
      guard++;
    end while (!rdy && guard < 20);
    if (!rdy) begin
      n_checks++; n_fail++;
      $display("FAIL %s_accept: in_ready never rose within 20 cycles", name);
    end
    acc_cyc     = cyc;
    in_valid    = 1'b0;
    cfg_we      = 1'b0;
    in_features = mkfeat(8'($urandom()));
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!out_valid && lat < 40);
    chk({name, "_lat"}, lat, exp_lat);
    chk({name, "_class"}, int'(out_class), exp_cls);
    chk({name, "_error"}, int'(out_error), exp_err);
    for (int i = 0; i < hold; i++) begin
      cfg_we = 1'b1; cfg_addr = 6'd1; cfg_wdata = mk(1, 0, 3, 0, 0);
      @(posedge clk); #1;
      chk({name, "_hold_valid"}, int'(out_valid), 1);
      chk({name, "_hold_class"}, int'(out_class), exp_cls);
      chk({name, "_hold_in_ready"}, int'(in_ready), 0);
    end
    cfg_we    = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    int a0, a1, a2;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_class", int'(out_class), 0);
    chk("rst_out_error", int'(out_error), 0);
    chk("rst_busy", int'(busy), 0);

    run_sample("rst_tbl", 8'hAA, 0, 1, 16, 0, a0);

    write_node(0, mk(0, 15, 31, 1, 2));
    write_node(1, mk(1, 0, 8, 0, 0));
    write_node(2, mk(0, 15, 127, 3, 4));
    write_node(3, mk(1, 0, 4, 0, 0));
    write_node(4, mk(1, 0, 9, 0, 0));
    run_sample("f20", 8'd20, 8, 0, 2, 0, a0);
    run_sample("f100", 8'd100, 4, 0, 3, 0, a0);
    run_sample("f200", 8'd200, 9, 0, 3, 0, a0);
    run_sample("f31", 8'd31, 8, 0, 2, 0, a0);
    run_sample("f32", 8'd32, 4, 0, 3, 0, a0);

    run_sample("bp", 8'd20, 8, 0, 2, 5, a0);
    run_sample("after_bp", 8'd20, 8, 0, 2, 0, a0);

    write_node(0, mk(1, 0, 5, 0, 0));
    run_sample("leaf_a", 8'd0, 5, 0, 1, 0, a0);
    run_sample("leaf_b", 8'd0, 5, 0, 1, 0, a1);
    run_sample("leaf_c", 8'd0, 5, 0, 1, 0, a2);
    chk("b2b_spacing_1", a1 - a0, 3);
    chk("b2b_spacing_2", a2 - a1, 3);

    cfg_we = 1'b1; cfg_addr = 6'd0; cfg_wdata = mk(1, 0, 7, 0, 0);
    run_sample("same_cycle_wr", 8'd0, 7, 0, 1, 0, a0);

    write_node(0, mk(0, 15, 31, 1, 2));
    in_features = mkfeat(8'd100);
    in_valid    = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_in_ready", int'(in_ready), 1);
    chk("midrst_busy", int'(busy), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("postrst_in_ready", int'(in_ready), 1);
    chk("postrst_out_valid", int'(out_valid), 0);
    run_sample("after_rst", 8'd100, 0, 1, 16, 0, a0);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
